std_reg_wr_sched: RTL
=====================

# std_reg_wr_sched

Write scheduler for a shared bank of enabled, resettable register entries. It shares the bank's single write port between `NREQ` requesters with round-robin arbitration and issues at most one registered write per cycle. It optionally sweeps an initial value into every entry after reset. It sits in the L1D control path between producers of configuration/state updates and the bank of enable flops.

## Interface

**Parameters**
- `NREQ`, 4: number of requesters, at least 2.
- `DEPTH`, 8: number of register entries in the bank, at least 2.
- `WIDTH`, 8: data width of each entry.
- `ADDR_W`, `$clog2(DEPTH)`: entry address width (derived).
- `INIT_VAL`, 0: value written to every entry by the init sweep.

**Ports**
- `clk`, in, 1: clock. One clock domain.
- `rst`, in, 1: reset. Synchronous and active-high.
- `stall`, in, 1: when high, blocks all new grants.
- `req_vld`, in, `NREQ`: per-requester write request valid.
- `req_addr`, in, `NREQ*ADDR_W`: per-requester entry address. Requester i uses slice i.
- `req_data`, in, `NREQ*WIDTH`: per-requester write data.
- `req_rdy`, out, `NREQ`: grant. At most one bit is high.
- `reg_wen`, out, `DEPTH`: one-hot write enable to the bank entries. Registered.
- `reg_wdata`, out, `WIDTH`: write data to the bank. Registered.
- `wr_err`, out, 1: one-cycle pulse, an accepted request carried an address at or above `DEPTH`. Registered.
- `busy`, out, 1: high while the scheduler is in the INIT state.

## Operation

**FSM states:** INIT, ARB.
- Reset state is INIT when `STD_REG_WR_SCHED_INIT_EN` is defined, otherwise ARB.
- INIT: counter `cnt` steps 0 to `DEPTH-1`, one entry per cycle. Each step issues a write of `INIT_VAL` to entry `cnt`.
  - After the step with `cnt == DEPTH-1`, go to ARB.
  - `stall` and `req_vld` are ignored in INIT. `req_rdy` is all zero.
- ARB: round-robin arbitration among the set bits of `req_vld`.
  - Search starts at pointer `ptr` and wraps at `NREQ-1` to 0.
  - The first valid requester found gets `req_rdy` high, combinationally in the same cycle.
  - `req_rdy` is all zero when `stall` is high or when no request is valid.
- Handshake: a transfer happens when `req_vld[i] && req_rdy[i]`. On a transfer, `ptr` becomes `(i+1) mod NREQ`. With no transfer, `ptr` holds.
- Write issue: in the cycle after a transfer, `reg_wen` is one-hot at `req_addr[i]` and `reg_wdata` equals `req_data[i]`.
- Out-of-range address (`addr >= DEPTH`): the transfer still completes. `reg_wen` stays all zero and `wr_err` pulses for one cycle.
- Two requesters targeting the same address in the same cycle: only the granted one writes. The other keeps its request pending.
- A requester may drop `req_vld` without a grant. Nothing is written for it.

## Timing

- Reset values: `reg_wen=0`, `reg_wdata=0`, `wr_err=0`, `ptr=0`, `cnt=0`. `busy` is 1 with INIT built in, 0 without. `req_rdy=0` during reset.
- Latency: 1 cycle from handshake to `reg_wen`. Throughput is one write per cycle.
- The init sweep takes exactly `DEPTH` cycles. `busy` falls in the cycle after the final init write is issued, and ARB grants are possible in that same cycle.
- `rst` asserted mid-sweep or mid-arbitration:
  - The next cycle is the reset state, with `cnt` and `ptr` cleared.
  - A registered write pending in that cycle is squashed: `reg_wen=0`.
- `stall` takes effect in the same cycle it is asserted. A write already registered from the previous cycle still issues.

## Configuration

- `STD_REG_WR_SCHED_INIT_EN` defined: the INIT state, `cnt` and the sweep are compiled in. Every reset produces a `DEPTH`-cycle `INIT_VAL` sweep with `busy` high.
- Not defined: INIT and `cnt` are removed. The FSM is ARB-only from reset, `busy` is tied to 0, and `INIT_VAL` is unused.

## Test plan

1. **Init sweep.** Macro on, `DEPTH=8`, `INIT_VAL=0x5A`, `rst` released at cycle 0.
   - `reg_wen` goes 0x01, 0x02, …, 0x80 on cycles 1 to 8, with `reg_wdata=0x5A`.
   - `busy` is low from cycle 8 on.
   - `req_rdy` is 0 throughout, even with `req_vld=0xF`.
2. **Round-robin fairness.** `req_vld=0xF` held for 8 cycles, distinct addresses.
   - Grants go 0,1,2,3,0,1,2,3.
   - Each write appears one cycle after its grant with the matching data.
3. **Same-address conflict.** req0 writes addr 3 = 0x11 and req2 writes addr 3 = 0x22 in the same cycle, `ptr=0`.
   - req0 is granted first; req2 is granted the next cycle.
   - Entry 3 receives 0x11, then 0x22.
4. **Stall.** `stall=1` with `req_vld=0x2` for 3 cycles.
   - `req_rdy=0` and no new `reg_wen` while stalled.
   - One cycle after `stall` drops, `reg_wen` is asserted for req1's address.
5. **Out-of-range address.** `DEPTH=6`, req1 address 7.
   - The grant completes.
   - Next cycle: `reg_wen=0`, `wr_err=1` for exactly one cycle.
6. **Reset mid-sweep.** `rst` asserted at sweep step 4, held 1 cycle, then released.
   - No write reaches entry 4 or above from the first sweep.
   - The sweep restarts at entry 0 and `ptr` is 0 afterwards.

Source files
------------

// File: rtl/std_reg_wr_sched.sv
// std_reg_wr_sched: round-robin write scheduler for a bank of enable flops.
// NREQ requesters share one registered write port; at most one write per cycle.
// Optional feature macro: STD_REG_WR_SCHED_INIT_EN adds a post-reset sweep
// that writes INIT_VAL into every entry, with busy high while it runs.
module std_reg_wr_sched #(
  parameter int              NREQ     = 4,
  parameter int              DEPTH    = 8,
  parameter int              WIDTH    = 8,
  parameter int              ADDR_W   = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic [NREQ-1:0]         req_vld,
  input  logic [NREQ*ADDR_W-1:0]  req_addr,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_rdy,
  output logic [DEPTH-1:0]        reg_wen,
  output logic [WIDTH-1:0]        reg_wdata,
  output logic                    wr_err,
  output logic                    busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [ADDR_W-1:0] addr_arr [NREQ];
  logic [WIDTH-1:0]  data_arr [NREQ];
  logic [NREQ-1:0]   oor_arr;

  logic [PTR_W-1:0]  ptr_reg;
  logic [PTR_W-1:0]  ptr_next;
  logic [PTR_W-1:0]  gnt_idx;
  logic              gnt_vld;
  logic              arb_en;

  // Unpack the flat request buses and flag addresses past the last entry.
  // When DEPTH fills the address space no address can be out of range.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign data_arr[gi] = req_data[gi*WIDTH +: WIDTH];
      if (DEPTH == (1 << ADDR_W)) begin : g_full
        assign oor_arr[gi] = 1'b0;
      end else begin : g_part
        assign oor_arr[gi] = ({1'b0, addr_arr[gi]} >= (ADDR_W+1)'(DEPTH));
      end
    end
  endgenerate

`ifdef STD_REG_WR_SCHED_INIT_EN
  typedef enum logic {ST_INIT = 1'b0, ST_ARB = 1'b1} state_t;
  state_t            state_reg;
  logic [ADDR_W-1:0] cnt_reg;

  assign arb_en = (state_reg == ST_ARB);
  assign busy   = (state_reg == ST_INIT);
`else
  assign arb_en = 1'b1;
  assign busy   = 1'b0;
`endif

  // Round-robin search starting at ptr_reg; the first valid requester wins.
  always_comb begin
    int idx;
    idx      = 0;
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    req_rdy  = '0;
    if (arb_en && !stall && !rst) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr_reg) + k) % NREQ;
        if (!gnt_vld && req_vld[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = PTR_W'(idx);
        end
      end
    end
    if (gnt_vld) begin
      req_rdy[gnt_idx] = 1'b1;
    end
  end

  // Pointer moves just past the winner, wrapping at NREQ-1.
  assign ptr_next = (gnt_idx == PTR_W'(NREQ-1)) ? '0 : gnt_idx + PTR_W'(1);

  // State, pointer, sweep counter and the registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef STD_REG_WR_SCHED_INIT_EN
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
`endif
      ptr_reg   <= '0;
      reg_wen   <= '0;
      reg_wdata <= '0;
      wr_err    <= 1'b0;
    end else begin
      reg_wen <= '0;
      wr_err  <= 1'b0;
`ifdef STD_REG_WR_SCHED_INIT_EN
      if (state_reg == ST_INIT) begin
        reg_wen   <= DEPTH'(1) << cnt_reg;
        reg_wdata <= INIT_VAL;
        if (cnt_reg == ADDR_W'(DEPTH-1)) begin
          cnt_reg   <= '0;
          state_reg <= ST_ARB;
        end else begin
          cnt_reg <= cnt_reg + ADDR_W'(1);
        end
      end else
`endif
      if (gnt_vld) begin
        ptr_reg   <= ptr_next;
        reg_wdata <= data_arr[gnt_idx];
        wr_err    <= oor_arr[gnt_idx];
        if (!oor_arr[gnt_idx]) begin
          reg_wen <= DEPTH'(1) << addr_arr[gnt_idx];
        end
      end
    end
  end

endmodule
